// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks irq/exception/mret at commit, drains the LSU,
// strobes the mepc/mcause write, then hands a redirect target to the IFU.
module trap_ctrl #(
   parameter int DRAIN_MAX = 64,
   parameter int CNT_W     = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [31:0] instr_pc,
   input  logic        ecall,
   input  logic        ebreak,
   input  logic        illegal,
   input  logic        mret,
   input  logic        irq_timer,
   input  logic        mstatus_mie,
   input  logic [31:0] mtvec_rdata,
   input  logic [31:0] mepc_rdata,
   input  logic        lsu_busy,
   input  logic        redirect_ready,
   output logic        stall,
   output logic        exception_en,
   output logic [31:0] mepc_wdata,
   output logic [31:0] mcause_wdata,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        drain_err
);

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

   localparam logic [31:0] CAUSE_IRQ     = 32'h8000_0007;
   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
   localparam logic [31:0] CAUSE_ECALL   = 32'd11;
   localparam logic [31:0] ALIGN_MASK    = ~32'h3;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] drain_cnt;
   logic [31:0]      cause_q;
   logic [31:0]      pc_q;
   logic             is_mret_q;

   logic             take_irq;
   logic             trap_req;
   logic             accept;
   logic [31:0]      cause_sel;

   assign take_irq = irq_timer & mstatus_mie;
   assign trap_req = take_irq | illegal | ebreak | ecall;
   assign accept   = (state == IDLE) & instr_valid & (trap_req | mret);
   assign stall    = (state != IDLE) | accept;

   // NOTE: cause_sel gets a default first so no path through the block infers a latch.
   always_comb begin
      cause_sel = '0;
      if (take_irq)     cause_sel = CAUSE_IRQ;
      else if (illegal) cause_sel = CAUSE_ILLEGAL;
      else if (ebreak)  cause_sel = CAUSE_EBREAK;
      else if (ecall)   cause_sel = CAUSE_ECALL;
   end

   // NOTE: every register below uses <=, so all branches read pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         drain_cnt      <= '0;
         cause_q        <= '0;
         pc_q           <= '0;
         is_mret_q      <= 1'b0;
         exception_en   <= 1'b0;
         mepc_wdata     <= '0;
         mcause_wdata   <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         drain_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  drain_cnt <= '0;
                  pc_q      <= instr_pc;
                  cause_q   <= cause_sel;
                  is_mret_q <= ~trap_req;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (lsu_busy) begin
                  // Counter saturates at DRAIN_MAX; the error is flagged as it gets there.
                  if (drain_cnt != CNT_MAX) drain_cnt <= drain_cnt + CNT_ONE;
                  if (drain_cnt == CNT_MAX - CNT_ONE) drain_err <= 1'b1;
               end else if (is_mret_q) begin
                  redirect_pc    <= mepc_rdata & ALIGN_MASK;
                  redirect_valid <= 1'b1;
                  state          <= REDIRECT;
               end else begin
                  exception_en <= 1'b1;
                  mepc_wdata   <= pc_q;
                  mcause_wdata <= cause_q;
                  state        <= COMMIT;
               end
            end
            COMMIT: begin
               exception_en   <= 1'b0;
               mepc_wdata     <= '0;
               mcause_wdata   <= '0;
               redirect_pc    <= mtvec_rdata & ALIGN_MASK;
               redirect_valid <= 1'b1;
               state          <= REDIRECT;
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: table of single-instruction vectors plus hand-written drain,
// backpressure, back-to-back and mid-sequence reset sequences, checked via a scoreboard.
module tb_trap_ctrl;

   localparam int DRAIN_MAX = 3;
   localparam int CNT_W     = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr_pc = '0;
   logic        ecall = 1'b0, ebreak = 1'b0, illegal = 1'b0, mret = 1'b0;
   logic        irq_timer = 1'b0, mstatus_mie = 1'b0;
   logic [31:0] mtvec_rdata = '0, mepc_rdata = '0;
   logic        lsu_busy = 1'b0, redirect_ready = 1'b1;
   logic        stall, exception_en, redirect_valid, drain_err;
   logic [31:0] mepc_wdata, mcause_wdata, redirect_pc;

   trap_ctrl #(.DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_pc(instr_pc),
      .ecall(ecall), .ebreak(ebreak), .illegal(illegal), .mret(mret),
      .irq_timer(irq_timer), .mstatus_mie(mstatus_mie), .mtvec_rdata(mtvec_rdata),
      .mepc_rdata(mepc_rdata), .lsu_busy(lsu_busy), .redirect_ready(redirect_ready),
      .stall(stall), .exception_en(exception_en), .mepc_wdata(mepc_wdata),
      .mcause_wdata(mcause_wdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .drain_err(drain_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        ecall, ebreak, illegal, mret, irq, mie;
      logic [31:0] pc, mtvec, mepc;
      logic        act, is_mret;
      logic [31:0] cause, rpc;
   } vec_t;

   typedef struct {
      logic [31:0] cause, mepc, rpc;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: CSR write and redirect are matched against the oldest accepted trap.
   task automatic sb_monitor();
      exp_t e;
      if (exception_en) begin
         if (sb_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL sb_exc: exception_en with no trap pending (t=%0t)", $time);
         end else begin
            e = sb_q[0];
            check("sb_mcause", mcause_wdata, e.cause);
            check("sb_mepc", mepc_wdata, e.mepc);
         end
      end
      if (redirect_valid && redirect_ready) begin
         if (sb_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL sb_redirect: handshake with nothing pending (t=%0t)", $time);
         end else begin
            e = sb_q.pop_front();
            check("sb_redirect_pc", redirect_pc, e.rpc);
         end
      end
      if (!reset) sb_q.delete();
   endtask

   task automatic settle();
      @(negedge clock);
      sb_monitor();
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_instr();
      instr_valid = 1'b0;
      ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0; mret = 1'b0; irq_timer = 1'b0;
   endtask

   task automatic drive_instr(input vec_t v);
      instr_valid = 1'b1;
      instr_pc    = v.pc;
      ecall = v.ecall; ebreak = v.ebreak; illegal = v.illegal; mret = v.mret;
      irq_timer = v.irq; mstatus_mie = v.mie;
      mtvec_rdata = v.mtvec; mepc_rdata = v.mepc;
      if (v.act) sb_q.push_back('{v.cause, v.pc, v.rpc});
   endtask

   task automatic check_zero(input string tag);
      check1({tag, "_stall"}, stall, 1'b0);
      check1({tag, "_exc"}, exception_en, 1'b0);
      check({tag, "_mepc_wdata"}, mepc_wdata, 32'h0);
      check({tag, "_mcause_wdata"}, mcause_wdata, 32'h0);
      check1({tag, "_rvalid"}, redirect_valid, 1'b0);
      check({tag, "_rpc"}, redirect_pc, 32'h0);
      check1({tag, "_drain_err"}, drain_err, 1'b0);
   endtask

   // Applies one vector from T0 through its handshake cycle, LSU idle and ready high.
   task automatic apply_vec(input int idx, input vec_t v);
      int n;
      lsu_busy = 1'b0;
      redirect_ready = 1'b1;
      drive_instr(v);
      settle();
      check1($sformatf("v%0d_t0_stall", idx), stall, v.act);
      check1($sformatf("v%0d_t0_exc", idx), exception_en, 1'b0);
      advance();
      clear_instr();
      if (v.act) begin
         n = v.is_mret ? 2 : 3;
         for (int t = 1; t <= n; t++) begin
            settle();
            check1($sformatf("v%0d_t%0d_stall", idx, t), stall, 1'b1);
            check1($sformatf("v%0d_t%0d_exc", idx, t), exception_en, !v.is_mret && t == 2);
            check1($sformatf("v%0d_t%0d_rvalid", idx, t), redirect_valid, t == n);
            if (!(!v.is_mret && t == 2)) begin
               check($sformatf("v%0d_t%0d_mepc_zero", idx, t), mepc_wdata, 32'h0);
               check($sformatf("v%0d_t%0d_mcause_zero", idx, t), mcause_wdata, 32'h0);
            end
            advance();
         end
      end
   endtask

   task automatic idle_cycle(input string tag);
      clear_instr();
      settle();
      check1({tag, "_idle_stall"}, stall, 1'b0);
      check1({tag, "_idle_rvalid"}, redirect_valid, 1'b0);
      advance();
   endtask

   task automatic run_to_commit(input vec_t v);
      lsu_busy = 1'b0;
      drive_instr(v);
      settle();
      advance();
      clear_instr();
      settle();
      check1("seq_t1_stall", stall, 1'b1);
      advance();
   endtask

   vec_t vecs[10];
   vec_t v;

   initial begin
      //          ec    eb    il    mr    irq   mie   pc            mtvec         mepc          act   mret  cause         rpc
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h8000_0100, 32'h0,        1'b1, 1'b0, 32'd11,        32'h8000_0100};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0020, 32'h8000_0100, 32'h0,        1'b1, 1'b0, 32'h8000_0007, 32'h8000_0100};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0020, 32'h8000_0100, 32'h0,        1'b1, 1'b0, 32'd11,        32'h8000_0100};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0048, 32'h8000_0100, 32'h8000_0046, 1'b1, 1'b1, 32'h0,         32'h8000_0044};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0030, 32'h8000_0203, 32'h8000_0046, 1'b1, 1'b0, 32'd2,         32'h8000_0200};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0034, 32'h8000_0100, 32'h0,        1'b1, 1'b0, 32'd3,         32'h8000_0100};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0038, 32'h8000_0100, 32'h0,        1'b1, 1'b0, 32'h8000_0007, 32'h8000_0100};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_003c, 32'h8000_0100, 32'h0,        1'b0, 1'b0, 32'h0,         32'h0};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0040, 32'h8000_0100, 32'h0000_1237, 1'b1, 1'b1, 32'h0,         32'h0000_1234};
      vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0040, 32'h8000_0100, 32'h8000_0046, 1'b1, 1'b0, 32'h8000_0007, 32'h8000_0100};

      advance();
      advance();
      settle();
      check_zero("reset");
      reset = 1'b1;
      advance();

      for (int i = 0; i < 10; i++) begin
         apply_vec(i, vecs[i]);
         idle_cycle($sformatf("v%0d", i));
      end

      // Back-to-back: mret accepted in the IDLE cycle right after a trap's handshake.
      apply_vec(10, vecs[0]);
      apply_vec(11, vecs[3]);
      idle_cycle("b2b");

      // LSU busy for 5 cycles from accept: COMMIT at T6, drain_err set and sticky.
      v = vecs[0];
      v.pc = 32'h8000_0050;
      lsu_busy = 1'b1;
      drive_instr(v);
      settle();
      check1("drain_t0_stall", stall, 1'b1);
      check1("drain_t0_err", drain_err, 1'b0);
      advance();
      clear_instr();
      for (int t = 1; t <= 5; t++) begin
         lsu_busy = (t <= 4);
         settle();
         check1($sformatf("drain_t%0d_stall", t), stall, 1'b1);
         check1($sformatf("drain_t%0d_exc", t), exception_en, 1'b0);
         if (t == 2) check1("drain_t2_err", drain_err, 1'b0);
         advance();
      end
      settle();
      check1("drain_t6_exc", exception_en, 1'b1);
      check1("drain_t6_err", drain_err, 1'b1);
      advance();
      settle();
      check1("drain_t7_rvalid", redirect_valid, 1'b1);
      advance();
      idle_cycle("drain");
      apply_vec(12, vecs[5]);
      settle();
      check1("drain_err_sticky", drain_err, 1'b1);
      advance();

      // IFU backpressure: ready low for 4 REDIRECT cycles, target held stable.
      v = vecs[0];
      v.pc = 32'h8000_0080;
      v.mtvec = 32'h8000_0107;
      v.rpc = 32'h8000_0104;
      redirect_ready = 1'b0;
      run_to_commit(v);
      settle();
      check1("bp_t2_exc", exception_en, 1'b1);
      advance();
      for (int t = 3; t <= 6; t++) begin
         settle();
         check1($sformatf("bp_t%0d_rvalid", t), redirect_valid, 1'b1);
         check1($sformatf("bp_t%0d_stall", t), stall, 1'b1);
         check($sformatf("bp_t%0d_rpc", t), redirect_pc, 32'h8000_0104);
         advance();
      end
      redirect_ready = 1'b1;
      settle();
      check1("bp_t7_rvalid", redirect_valid, 1'b1);
      advance();
      idle_cycle("bp");

      // Reset while in COMMIT, then a clean illegal trap.
      v = vecs[0];
      v.pc = 32'h8000_0060;
      run_to_commit(v);
      reset = 1'b0;
      settle();
      check1("rst_commit_exc", exception_en, 1'b1);
      advance();
      reset = 1'b1;
      settle();
      check_zero("rst_commit");
      advance();
      v = vecs[4];
      v.ecall = 1'b0; v.ebreak = 1'b0; v.mret = 1'b0;
      v.pc = 32'h8000_0000; v.mtvec = 32'h8000_0100; v.rpc = 32'h8000_0100;
      apply_vec(13, v);
      idle_cycle("rst_commit_after");

      // Reset while in REDIRECT with the IFU stalled.
      v = vecs[0];
      v.pc = 32'h8000_0070;
      redirect_ready = 1'b0;
      run_to_commit(v);
      settle();
      advance();
      reset = 1'b0;
      settle();
      check1("rst_redir_rvalid", redirect_valid, 1'b1);
      advance();
      reset = 1'b1;
      redirect_ready = 1'b1;
      settle();
      check_zero("rst_redir");
      advance();
      v = vecs[4];
      v.ecall = 1'b0; v.ebreak = 1'b0; v.mret = 1'b0;
      v.pc = 32'h8000_0000; v.mtvec = 32'h8000_0100; v.rpc = 32'h8000_0100;
      apply_vec(14, v);
      idle_cycle("rst_redir_after");

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer for the machine-mode CSR file. Watches the commit-stage instruction and selects one action by priority: timer interrupt, synchronous exception, or mret. It stalls the pipeline, waits for outstanding LSU traffic to drain, pulses the CSR file's exception write (mepc/mcause), then issues a PC redirect to mtvec or mepc through a valid/ready handshake with the IFU.

Parameters:
DRAIN_MAX, 64, max cycles to wait in DRAIN for lsu_busy to fall before flagging drain_err (must be >=1)
CNT_W, 7, width of drain counter (must hold DRAIN_MAX)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clock)
instr_valid  input  1  commit-stage instruction present
instr_pc  input  32  PC of commit-stage instruction
ecall  input  1  instruction is ecall
ebreak  input  1  instruction is ebreak
illegal  input  1  instruction is illegal
mret  input  1  instruction is mret
irq_timer  input  1  level timer interrupt request
mstatus_mie  input  1  global interrupt enable (mstatus[3])
mtvec_rdata  input  32  current mtvec from CSR file
mepc_rdata  input  32  current mepc from CSR file
lsu_busy  input  1  LSU has an outstanding transaction
redirect_ready  input  1  IFU accepts redirect
stall  output  1  hold pipeline / block commit
exception_en  output  1  one-cycle CSR write strobe for mepc/mcause
mepc_wdata  output  32  captured trap PC
mcause_wdata  output  32  captured cause
redirect_valid  output  1  redirect request
redirect_pc  output  32  redirect target
drain_err  output  1  sticky: DRAIN exceeded DRAIN_MAX

Behaviour:
- States: IDLE, DRAIN, COMMIT, REDIRECT. Reset (reset==0) forces IDLE from any state, including mid-sequence. On reset: all outputs 0, captured registers 0, drain_err 0.
- Accept condition in IDLE: instr_valid && (take_irq || illegal || ebreak || ecall || mret), where take_irq = irq_timer && mstatus_mie.
- Priority: take_irq > illegal > ebreak > ecall > mret. Only the winner is acted on.
- Cause codes: irq 32'h8000_0007; illegal 32'd2; ebreak 32'd3; ecall 32'd11. mepc capture = instr_pc for all traps, including interrupts, since the instruction is not retired.
- Accept cycle (T0): register cause, pc and an is_mret flag, then go to DRAIN. stall is combinational and asserted in T0: stall = (state!=IDLE) | accept.
- DRAIN: stall=1. The counter starts at 0 on entry and increments each cycle lsu_busy==1. When lsu_busy==0, exit to COMMIT (trap) or REDIRECT (mret). For mret, redirect_pc <= mepc_rdata & ~32'h3 on the exit edge. If the counter reaches DRAIN_MAX, set drain_err (sticky until reset) and keep waiting. There is no forced exit.
- COMMIT: exactly one cycle. exception_en=1 and mepc_wdata/mcause_wdata show the captured values; both data outputs are 0 whenever exception_en=0. redirect_pc <= {mtvec_rdata[31:2],2'b00} (direct mode only), then go to REDIRECT.
- REDIRECT: redirect_valid=1 and stall=1, with redirect_pc held stable. Leave to IDLE on the cycle redirect_valid && redirect_ready. Do not deassert redirect_valid before that. stall drops in the cycle after the handshake.
- Minimum latency, lsu idle, ready tied high: trap T0 accept, T1 DRAIN, T2 COMMIT, T3 REDIRECT handshake, T4 IDLE. mret is one cycle shorter.
- Inputs while not IDLE are ignored. Upstream holds commit because stall=1. irq_timer is level-sensitive and is not latched. An irq that drops before an instr_valid cycle is lost, which is intended.
- instr_valid with no flags set and no take_irq: no action, stall=0.
- mret with mstatus_mie=0 and no other flag: normal mret path. No mstatus update is made here.
- lsu_busy toggling in DRAIN: the exit decision uses the current-cycle value only. The counter does not reset on a toggle.
- Back-to-back: a new accept is allowed in the IDLE cycle right after REDIRECT completes.

Test Plan:
- ecall at pc 0x8000_0010, mtvec 0x8000_0100, lsu idle, ready=1 -> exception_en one pulse at T2 with mepc_wdata 0x8000_0010 and mcause 11; redirect_pc 0x8000_0100 at T3; stall high T0–T3.
- irq_timer=1, mie=1, with ecall on the same instruction (pc 0x8000_0020) -> mcause 0x8000_0007, mepc 0x8000_0020. Repeat with mie=0 -> mcause 11.
- mret with mepc_rdata 0x8000_0046 -> no exception_en; redirect_pc 0x8000_0044 at T2.
- lsu_busy held 5 cycles after accept, DRAIN_MAX=3 -> COMMIT at T6, drain_err=1 and stays set. Next trap with lsu idle -> drain_err still 1.
- redirect_ready low for 4 cycles -> redirect_valid and redirect_pc stable throughout; IDLE only after the handshake.
- Assert reset in COMMIT and in REDIRECT -> next cycle IDLE with all outputs 0; an illegal at pc 0x8000_0000 afterwards completes normally with mcause 2.
